// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
// ID/EX pipeline slot feeding the ALU. Holds one decoded instruction, resolves
// its source operands through EX/MEM and MEM/WB forwarding every cycle, and
// blocks decode on load-use hazards.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid & ready are both high. Producers keep valid and payload stable
// until the transfer. in_ready is combinational:
//   in_ready = ~flush & ~hazard & (~out_valid | out_ready)
// so a simultaneous transfer-out and transfer-in reloads the slot with no
// bubble.
//
// Optional build macro: IDEX_PERF_CNT_EN adds perf_stall_cnt and
// perf_flush_cnt (32-bit, wrapping) output ports.
module id_ex_operand_stage #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  // decode side
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_rs1_data,
  input  logic [XLEN-1:0]    in_rs2_data,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [REGADDR-1:0] in_rs1,
  input  logic [REGADDR-1:0] in_rs2,
  input  logic               in_use_rs1,
  input  logic               in_use_rs2,
  input  logic [REGADDR-1:0] in_rd,
  input  logic               in_alu_src,
  input  logic [3:0]         in_alu_control,
  input  logic               in_reg_write,
  input  logic               in_mem_read,
  input  logic               in_mem_write,
  input  logic               in_branch,
  // forwarding sources
  input  logic               exmem_reg_write,
  input  logic               exmem_mem_read,
  input  logic [REGADDR-1:0] exmem_rd,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic               memwb_reg_write,
  input  logic [REGADDR-1:0] memwb_rd,
  input  logic [XLEN-1:0]    memwb_result,
  // execute side
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    alu_a,
  output logic [XLEN-1:0]    alu_b,
  output logic [3:0]         alu_control,
  output logic [XLEN-1:0]    store_data,
  output logic [REGADDR-1:0] rd,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               branch
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  // Slot contents that are not directly visible as outputs
  logic [XLEN-1:0]    rs1_val;
  logic [XLEN-1:0]    rs2_val;
  logic [XLEN-1:0]    imm;
  logic [REGADDR-1:0] rs1;
  logic [REGADDR-1:0] rs2;
  logic               alu_src;

  logic [XLEN-1:0]    fwd_rs1;
  logic [XLEN-1:0]    fwd_rs2;
  logic               hazard;
  logic               haz_rs1;
  logic               haz_rs2;
  logic               take_in;
  logic               take_out;

  // Per-source forwarding: EX/MEM beats MEM/WB beats the slot's own value; x0 never forwards
  always_comb begin
    fwd_rs1 = rs1_val;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs1))
      fwd_rs1 = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1))
      fwd_rs1 = memwb_result;

    fwd_rs2 = rs2_val;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs2))
      fwd_rs2 = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2))
      fwd_rs2 = memwb_result;
  end

  // Load-use detection: a used source waits on a load still in this slot or in EX/MEM
  always_comb begin
    haz_rs1 = in_use_rs1 && (in_rs1 != '0) &&
              ((out_valid && mem_read && (rd == in_rs1)) ||
               (exmem_mem_read && (exmem_rd == in_rs1)));
    haz_rs2 = in_use_rs2 && (in_rs2 != '0) &&
              ((out_valid && mem_read && (rd == in_rs2)) ||
               (exmem_mem_read && (exmem_rd == in_rs2)));
    hazard  = in_valid && (haz_rs1 || haz_rs2);
  end

  // Handshake decode and ALU operand muxing
  always_comb begin
    in_ready   = ~flush & ~hazard & (~out_valid | out_ready);
    take_in    = in_valid & in_ready;
    take_out   = out_valid & out_ready;
    alu_a      = fwd_rs1;
    alu_b      = alu_src ? imm : fwd_rs2;
    store_data = fwd_rs2;
  end

  // Slot register: reset/flush clear, capture on transfer-in, drain on transfer-out, refresh operands while held
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid   <= 1'b0;
      rs1_val     <= '0;
      rs2_val     <= '0;
      imm         <= '0;
      rs1         <= '0;
      rs2         <= '0;
      alu_src     <= 1'b0;
      alu_control <= 4'b0000;
      rd          <= '0;
      reg_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      branch      <= 1'b0;
    end else if (take_in) begin
      out_valid   <= 1'b1;
      rs1_val     <= in_rs1_data;
      rs2_val     <= in_rs2_data;
      imm         <= in_imm;
      rs1         <= in_rs1;
      rs2         <= in_rs2;
      alu_src     <= in_alu_src;
      alu_control <= in_alu_control;
      rd          <= in_rd;
      reg_write   <= in_reg_write;
      mem_read    <= in_mem_read;
      mem_write   <= in_mem_write;
      branch      <= in_branch;
    end else if (take_out) begin
      out_valid   <= 1'b0;
    end else if (out_valid) begin
      // Held: latch the forwarded values so they outlive the producer's retirement
      rs1_val     <= fwd_rs1;
      rs2_val     <= fwd_rs2;
    end
  end

`ifdef IDEX_PERF_CNT_EN
  // Performance counters: stalled-offer cycles and flushes that killed a live instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (hazard && in_valid)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush && out_valid)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
